// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM generator.
// Defaults describe standard hobby servos driven from a 50 MHz clock.
package servo_pkg;

    localparam int unsigned DEF_CLK_HZ    = 50_000_000;
    localparam int unsigned DEF_PERIOD    = 1_000_000;
    localparam int unsigned DEF_MIN_PULSE = 25_000;
    localparam int unsigned DEF_MAX_PULSE = 125_000;
    localparam int unsigned DEF_LSB_CYC   = 392;

    // Legal channel count range and conversion arithmetic width.
    localparam int unsigned MIN_CH = 1;
    localparam int unsigned MAX_CH = 16;
    localparam int unsigned CONV_W = 64;

    // Position to pulse width; the wide product cannot wrap before the clamp.
    function automatic logic [CONV_W-1:0] pos_to_pulse(
        input logic [CONV_W-1:0] pos,
        input logic [CONV_W-1:0] min_pulse,
        input logic [CONV_W-1:0] lsb_cyc,
        input logic [CONV_W-1:0] max_pulse
    );
        logic [CONV_W-1:0] raw;
        raw = min_pulse + pos * lsb_cyc;
        return (raw > max_pulse) ? max_pulse : raw;
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: active flag, target/current pulse width, per-frame
// slew limiting and the registered output compare against the frame counter.
module servo_slew_channel
    import servo_pkg::*;
#(
    parameter int CNT_W_P     = 20,
    parameter int PW_W_P      = 17,
    parameter int MIN_PULSE_P = 25000,
    parameter int STEP_P      = 0
) (
    input  logic               Clk_i,
    input  logic               Reset_i,
    input  logic               Enable_i,
    input  logic               Wr_en_i,
    input  logic [PW_W_P-1:0]  Wr_pulse_i,
    input  logic               Commit_i,
    input  logic [CNT_W_P-1:0] Frame_cnt_i,
    output logic               Pwm_o
);

    localparam int CMP_W = (CNT_W_P > PW_W_P) ? CNT_W_P : PW_W_P;
    localparam logic [PW_W_P-1:0]        MIN_PW = PW_W_P'(MIN_PULSE_P);
    localparam logic [PW_W_P-1:0]        STEP_U = PW_W_P'(STEP_P);
    localparam logic signed [PW_W_P:0]   STEP_S = (PW_W_P+1)'(STEP_P);

    logic              active;
    logic [PW_W_P-1:0] tgt;
    logic [PW_W_P-1:0] cur;

    // Move cur toward tgt by at most STEP_P, landing exactly on tgt.
    function automatic logic [PW_W_P-1:0] slew_step(
        input logic [PW_W_P-1:0] cur_w,
        input logic [PW_W_P-1:0] tgt_w
    );
        logic signed [PW_W_P:0] diff;
        diff = $signed({1'b0, tgt_w}) - $signed({1'b0, cur_w});
        if (STEP_P == 0)
            return tgt_w;
        if (diff > STEP_S)
            return cur_w + STEP_U;
        if (diff < -STEP_S)
            return cur_w - STEP_U;
        return tgt_w;
    endfunction

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            active <= 1'b0;
            tgt    <= MIN_PW;
            cur    <= MIN_PW;
            Pwm_o  <= 1'b0;
        end else begin
            // Writes never coincide with a commit: ready is low in that cycle.
            if (Wr_en_i) begin
                tgt <= Wr_pulse_i;
                if (!active) begin
                    active <= 1'b1;
                    cur    <= Wr_pulse_i;
                end
            end else if (Commit_i && active) begin
                cur <= slew_step(cur, tgt);
            end
            Pwm_o <= Enable_i && active && (CMP_W'(Frame_cnt_i) < CMP_W'(cur));
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shared frame counter, write port decode
// and one slew-limited channel instance per servo output.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int CH_P        = 4,
    parameter int CH_W_P      = 2,
    parameter int POS_W_P     = 8,
    parameter int PERIOD_P    = 1000000,
    parameter int CNT_W_P     = 20,
    parameter int MIN_PULSE_P = 25000,
    parameter int MAX_PULSE_P = 125000,
    parameter int LSB_CYC_P   = 392,
    parameter int PW_W_P      = 17,
    parameter int STEP_P      = 0
) (
    input  logic               Clk_i,
    input  logic               Reset_i,
    input  logic               Enable_i,
    input  logic               Wr_valid_i,
    output logic               Wr_ready_o,
    input  logic [CH_W_P-1:0]  Wr_ch_i,
    input  logic [POS_W_P-1:0] Wr_pos_i,
    output logic [CH_P-1:0]    Pwm_o,
    output logic               Frame_start_o
);

    localparam logic [CNT_W_P-1:0] LAST_CNT = CNT_W_P'(PERIOD_P - 1);

    logic [CNT_W_P-1:0] frame_cnt;
    logic               commit;
    logic               wr_fire;
    logic [PW_W_P-1:0]  wr_pulse;
    logic [CH_P-1:0]    wr_sel;

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i)
            frame_cnt <= '0;
        else if (!Enable_i || frame_cnt == LAST_CNT)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt + 1'b1;
    end

    // Reset_i gating keeps every output low while reset is asserted.
    assign commit        = Enable_i && (frame_cnt == LAST_CNT);
    assign Wr_ready_o    = Reset_i && !commit;
    assign Frame_start_o = Reset_i && Enable_i && (frame_cnt == '0);
    assign wr_fire       = Wr_valid_i && Wr_ready_o;

    assign wr_pulse = PW_W_P'(pos_to_pulse(CONV_W'(Wr_pos_i), CONV_W'(MIN_PULSE_P),
                                           CONV_W'(LSB_CYC_P), CONV_W'(MAX_PULSE_P)));

    // Channel indices >= CH_P match no select line, so such writes vanish.
    for (genvar c = 0; c < CH_P; c++) begin : g_ch
        assign wr_sel[c] = wr_fire && (Wr_ch_i == CH_W_P'(c));

        servo_slew_channel #(
            .CNT_W_P     (CNT_W_P),
            .PW_W_P      (PW_W_P),
            .MIN_PULSE_P (MIN_PULSE_P),
            .STEP_P      (STEP_P)
        ) u_ch (
            .Clk_i       (Clk_i),
            .Reset_i     (Reset_i),
            .Enable_i    (Enable_i),
            .Wr_en_i     (wr_sel[c]),
            .Wr_pulse_i  (wr_pulse),
            .Commit_i    (commit),
            .Frame_cnt_i (frame_cnt),
            .Pwm_o       (Pwm_o[c])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi using shortened frames and a
// frame-level model of each channel's active/target/current width.
module tb_servo_pwm_multi;

    localparam int CH     = 3;
    localparam int PERIOD = 200;
    localparam int MINP   = 20;
    localparam int MAXP   = 120;
    localparam int LSB    = 1;
    localparam int STEP   = 30;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b0;
    logic          wr_valid = 1'b0;
    logic [1:0]    wr_ch    = '0;
    logic [7:0]    wr_pos   = '0;
    logic          wr_ready;
    logic          fs;
    logic [CH-1:0] pwm;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .CH_P        (CH),
        .CH_W_P      (2),
        .POS_W_P     (8),
        .PERIOD_P    (PERIOD),
        .CNT_W_P     (8),
        .MIN_PULSE_P (MINP),
        .MAX_PULSE_P (MAXP),
        .LSB_CYC_P   (LSB),
        .PW_W_P      (8),
        .STEP_P      (STEP)
    ) dut (
        .Clk_i         (clk),
        .Reset_i       (rst_n),
        .Enable_i      (en),
        .Wr_valid_i    (wr_valid),
        .Wr_ready_o    (wr_ready),
        .Wr_ch_i       (wr_ch),
        .Wr_pos_i      (wr_pos),
        .Pwm_o         (pwm),
        .Frame_start_o (fs)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int m_act[CH];
    int m_tgt[CH];
    int m_cur[CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int conv(input int pos);
        int w;
        w = MINP + pos * LSB;
        return (w > MAXP) ? MAXP : w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_act[c] = 0;
            m_tgt[c] = MINP;
            m_cur[c] = MINP;
        end
    endtask

    task automatic model_commit();
        for (int c = 0; c < CH; c++) begin
            if (m_act[c] != 0) begin
                if (m_tgt[c] - m_cur[c] > STEP)      m_cur[c] = m_cur[c] + STEP;
                else if (m_cur[c] - m_tgt[c] > STEP) m_cur[c] = m_cur[c] - STEP;
                else                                 m_cur[c] = m_tgt[c];
            end
        end
    endtask

    task automatic push_expected();
        for (int c = 0; c < CH; c++)
            exp_q.push_back((m_act[c] != 0) ? m_cur[c] : 0);
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        while (fs !== 1'b1 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (fs !== 1'b1) check({tag, " frame_start timeout"}, 32'(fs), 1);
    endtask

    // Count high cycles per channel over the frame that starts at Frame_start.
    task automatic measure_frame(input string tag);
        int hi[CH];
        int e;
        wait_fs(tag);
        for (int c = 0; c < CH; c++) hi[c] = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (pwm[c] === 1'b1) hi[c]++;
        end
        for (int c = 0; c < CH; c++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check($sformatf("%s ch%0d high", tag, c), 32'(hi[c]), 32'(e));
        end
    endtask

    task automatic do_write(input int ch, input int pos);
        int n;
        int w;
        n = 0;
        wr_valid = 1'b1;
        wr_ch    = ch[1:0];
        wr_pos   = pos[7:0];
        #1;
        while (wr_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (wr_ready !== 1'b1) check("write ready timeout", 32'(wr_ready), 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        if (ch < CH) begin
            w = conv(pos);
            if (m_act[ch] == 0) begin
                m_act[ch] = 1;
                m_cur[ch] = w;
            end
            m_tgt[ch] = w;
        end
        @(negedge clk);
    endtask

    initial begin : main
        int gap;

        repeat (3) @(negedge clk);
        check("reset pwm", 32'(pwm), 0);
        check("reset frame_start", 32'(fs), 0);
        check("reset ready", 32'(wr_ready), 0);
        model_reset();

        rst_n = 1'b1;
        en    = 1'b1;
        #1;
        check("first frame_start", 32'(fs), 1);
        push_expected(); measure_frame("idle f0");
        push_expected(); measure_frame("idle f1");
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (fs !== 1'b1 && gap < 2 * PERIOD);
        check("frame period", 32'(gap), PERIOD);

        // Initial loads on inactive channels, plus a clamp and an out-of-range channel.
        wait_fs("load");
        do_write(0, 0);
        do_write(1, 50);
        do_write(2, 255);
        do_write(3, 10);
        model_commit(); push_expected(); measure_frame("load");

        // Slew upward on ch0 and downward on ch2.
        do_write(0, 100);
        do_write(2, 0);
        for (int f = 0; f < 5; f++) begin
            model_commit(); push_expected(); measure_frame($sformatf("slew f%0d", f));
        end

        // Write held across the commit cycle.
        wait_fs("commit write");
        repeat (PERIOD - 2) @(negedge clk);
        check("ready before commit", 32'(wr_ready), 1);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_ch    = 2'd1;
        wr_pos   = 8'd0;
        #1;
        check("ready low in commit", 32'(wr_ready), 0);
        @(negedge clk);
        check("ready after commit", 32'(wr_ready), 1);
        check("frame_start after commit", 32'(fs), 1);
        model_commit();
        @(posedge clk);
        #1 wr_valid = 1'b0;
        m_tgt[1] = conv(0);
        model_commit(); push_expected(); measure_frame("late write f0");
        model_commit(); push_expected(); measure_frame("late write f1");

        // Disable mid-pulse, then resume.
        wait_fs("disable");
        repeat (5) @(negedge clk);
        check("pwm before disable", 32'(pwm), 7);
        en = 1'b0;
        @(negedge clk);
        check("pwm disabled", 32'(pwm), 0);
        check("frame_start disabled", 32'(fs), 0);
        check("ready disabled", 32'(wr_ready), 1);
        repeat (20) @(negedge clk);
        check("pwm still disabled", 32'(pwm), 0);
        en = 1'b1;
        #1;
        check("frame_start on enable", 32'(fs), 1);
        push_expected(); measure_frame("reenable");

        // Asynchronous reset mid-pulse.
        wait_fs("reset");
        repeat (3) @(negedge clk);
        check("pwm before reset", 32'(pwm), 7);
        #2 rst_n = 1'b0;
        #1;
        check("pwm async reset", 32'(pwm), 0);
        check("ready in reset", 32'(wr_ready), 0);
        check("frame_start in reset", 32'(fs), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        push_expected(); measure_frame("after reset");
        do_write(1, 10);
        model_commit(); push_expected(); measure_frame("rewrite");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Multi-channel servo PWM generator, the parametrised successor to the single-channel 3-angle servo driver. It drives CH_P servos from one shared frame counter. Each channel takes an arbitrary POS_W_P-bit position through a valid/ready write port. Optional per-frame slew limiting gives smooth motion. It sits between the control logic (UART/keypad decoder) and the servo output pins.

Parameters:
CH_P, 4, number of servo channels (1..16)
CH_W_P, 2, channel index width; must be >= clog2(CH_P), minimum 1
POS_W_P, 8, position word width
PERIOD_P, 1000000, frame length in clocks (20 ms at 50 MHz)
CNT_W_P, 20, frame counter width; 2^CNT_W_P > PERIOD_P
MIN_PULSE_P, 25000, pulse width for position 0 (0.5 ms)
MAX_PULSE_P, 125000, upper clamp on pulse width (2.5 ms)
LSB_CYC_P, 392, clocks added per position LSB
PW_W_P, 17, pulse-width register width; 2^PW_W_P > MAX_PULSE_P
STEP_P, 0, maximum pulse-width change per frame in clocks; 0 means no slew (jump immediately)

Ports:
Clk_i  in  1  system clock
Reset_i  in  1  asynchronous active-low reset
Enable_i  in  1  global enable
Wr_valid_i  in  1  position write request
Wr_ready_o  out  1  write accepted when valid && ready
Wr_ch_i  in  CH_W_P  target channel
Wr_pos_i  in  POS_W_P  target position
Pwm_o  out  CH_P  servo pulse outputs, bit c = channel c
Frame_start_o  out  1  one-cycle pulse at frame counter 0

Behaviour:
- Reset (async, active-low): all outputs 0.
  - Frame counter = 0.
  - All channels inactive; target and current widths = MIN_PULSE_P.
- Reset mid-frame: Pwm_o drops to 0 immediately (async). No state survives reset.
- Frame counter:
  - While Enable_i=1: counts 0..PERIOD_P-1, then wraps to 0.
  - While Enable_i=0: held at 0, Pwm_o forced to 0, Frame_start_o=0.
  - Channel active flags and target/current widths are retained while Enable_i=0.
- Frame_start_o = 1 in every cycle where Enable_i=1 and counter==0.
- Target conversion on an accepted write:
  - tgt = MIN_PULSE_P + Wr_pos_i*LSB_CYC_P, clamped to MAX_PULSE_P.
  - Default mapping: pos 0 -> 25000, pos 255 -> 124960.
- Write acceptance:
  - Wr_ready_o = 0 only in the commit cycle (Enable_i=1 and counter==PERIOD_P-1); otherwise 1, including while disabled.
  - A write with Wr_ch_i >= CH_P is accepted and discarded.
  - A write to an inactive channel sets active=1 and loads both target and current widths with tgt, with no slew.
  - A write to an active channel updates the target only.
  - Back-to-back writes to the same channel: the last accepted write wins.
- Commit (counter==PERIOD_P-1, Enable_i=1), for each active channel:
  - If STEP_P==0: cur <= tgt.
  - Otherwise: cur moves toward tgt by min(STEP_P, |tgt-cur|). cur never overshoots tgt.
- Output: Pwm_o[c] is registered. Pwm_o[c] = 1 iff Enable_i && active[c] && counter < cur[c], with one cycle of latency relative to the counter.
- Frame timing: the first high cycle of a frame follows the Frame_start_o cycle by one clock. High time = cur[c] clocks, period = PERIOD_P clocks.
- Width rules: the position multiply is computed at PW_W_P+POS_W_P bits before clamping. The slew subtract/compare uses PW_W_P+1 bits (signed).

Decomposition:
- Package servo_pkg holds: default timing constants (PERIOD, MIN, MAX, LSB_CYC at 50 MHz), the pos-to-pulse conversion function with clamp, and the width-check constants.
- Sub-module servo_slew_channel, instantiated CH_P times via generate. Each instance holds the active flag, target width, current width, slew logic and output compare. The top level holds the frame counter, write decode and ready logic.

Test Plan:
- Reset, Enable_i=1, no writes -> Pwm_o=0 for 2 frames; Frame_start_o pulses every 1000000 clocks.
- Write ch0 pos 0, ch1 pos 128, ch3 pos 255 -> next frame high times 25000, 75176, 124960 clocks; ch2 stays 0.
- STEP_P=10000: ch0 at pos 0, then write pos 255 -> high times 35000, 45000, ..., 124960 over 10 frames; no overshoot.
- Wr_valid_i held high across the commit cycle -> Wr_ready_o=0 for exactly that cycle; write accepted the next cycle and applied at the following commit.
- Write Wr_ch_i=3 with CH_P=3 -> accepted, no output change. Drop Enable_i mid-pulse -> Pwm_o=0 next cycle; re-enable -> same widths resume from counter 0.
- Assert Reset_i low mid-pulse -> Pwm_o=0 without a clock edge; after release all channels inactive until written.
